// File: rtl/proc_pkg.sv
// proc_pkg: instruction field positions, PC step and the fetch entry type
// shared by the fetch stage and its skid buffer.
package proc_pkg;
    localparam int ENTRY_PC_W   = 32;
    localparam int ENTRY_WORD_W = 32;
    localparam int TIPO_MSB     = 31;
    localparam int OP_MSB       = 29;
    localparam int INM_BIT      = 27;
    localparam int PC_STEP      = 4;
    typedef struct packed {
        logic [ENTRY_WORD_W-1:0] word;
        logic [ENTRY_PC_W-1:0]   pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry buffer holding a returned instruction word while the
// IF/ID stage is stalled; flush beats capture, capture beats drain.
module fetch_skid
    import proc_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_flush,
    input  logic         i_capture,
    input  logic         i_drain,
    input  fetch_entry_t i_entry,
    output logic         o_valid,
    output fetch_entry_t o_entry
);
    logic         r_valid;
    fetch_entry_t r_entry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_entry <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_capture) begin
            r_valid <= 1'b1;
            r_entry <= i_entry;
        end else if (i_drain) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_entry = r_entry;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC generation, synchronous instruction-memory requests and the
// registered IF/ID stage with stall skid buffer and PCsrc redirect.
module instr_fetch
    import proc_pkg::*;
#(
    parameter int              PC_W     = ENTRY_PC_W,
    parameter int              INSTR_W  = ENTRY_WORD_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               PCsrc,
    input  logic [PC_W-1:0]    pc_target,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [1:0]         tipo,
    output logic [1:0]         op,
    output logic               Inm,
    output logic [PC_W-1:0]    pc_out,
    output logic [PC_W-1:0]    pc_plus4
);
    logic [PC_W-1:0] r_fetch_pc;
    logic [PC_W-1:0] r_req_pc;
    logic            r_req_v;
    logic            r_ifid_v;
    fetch_entry_t    r_ifid;
    fetch_entry_t    w_mem_entry;
    fetch_entry_t    w_skid_entry;
    logic            w_skid_v;
    logic            w_skid_capture;
    logic            w_skid_drain;
    logic            w_load;

    assign w_mem_entry = {imem_rdata, r_req_pc};
    // Stalled: park the arriving word in an empty skid. Running: refill the
    // skid with the arriving word while the old skid entry moves into IF/ID.
    assign w_skid_capture = !PCsrc && r_req_v && (stall ? !w_skid_v : w_skid_v);
    assign w_skid_drain   = !PCsrc && !stall && w_skid_v;
    assign w_load         = w_skid_v || r_req_v;

    fetch_skid u_skid (
        .clk       (clk),
        .rst       (rst),
        .i_flush   (PCsrc),
        .i_capture (w_skid_capture),
        .i_drain   (w_skid_drain),
        .i_entry   (w_mem_entry),
        .o_valid   (w_skid_v),
        .o_entry   (w_skid_entry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_req_v    <= 1'b0;
            r_req_pc   <= '0;
            r_ifid_v   <= 1'b0;
            r_ifid     <= '0;
        end else if (PCsrc) begin
            r_fetch_pc <= pc_target;
            r_req_v    <= 1'b0;
            r_ifid_v   <= 1'b0;
        end else if (stall) begin
            r_req_v    <= 1'b0;
        end else begin
            r_fetch_pc <= r_fetch_pc + PC_W'(PC_STEP);
            r_req_v    <= 1'b1;
            r_req_pc   <= r_fetch_pc;
            r_ifid_v   <= w_load;
            if (w_load)
                r_ifid <= w_skid_v ? w_skid_entry : w_mem_entry;
        end
    end

    assign imem_addr   = r_fetch_pc;
    assign instr_valid = r_ifid_v;
    assign instr       = r_ifid.word;
    assign tipo        = r_ifid.word[TIPO_MSB -: 2];
    assign op          = r_ifid.word[OP_MSB -: 2];
    assign Inm         = r_ifid.word[INM_BIT];
    assign pc_out      = r_ifid.pc;
    assign pc_plus4    = r_ifid.pc + PC_W'(PC_STEP);
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed stimulus for instr_fetch against a stream-level
// model of which address IF/ID must hold each cycle.
module tb_instr_fetch;
    localparam int              PC_W     = 32;
    localparam int              INSTR_W  = 32;
    localparam logic [PC_W-1:0] RESET_PC = '0;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               stall = 1'b0;
    logic               PCsrc = 1'b0;
    logic [PC_W-1:0]    pc_target = '0;
    logic [INSTR_W-1:0] imem_rdata = '0;
    logic [PC_W-1:0]    imem_addr;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic [1:0]         tipo;
    logic [1:0]         op;
    logic               Inm;
    logic [PC_W-1:0]    pc_out;
    logic [PC_W-1:0]    pc_plus4;
    int                 total = 0;
    int                 bad = 0;

    instr_fetch #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .PCsrc       (PCsrc),
        .pc_target   (pc_target),
        .instr_valid (instr_valid),
        .instr       (instr),
        .tipo        (tipo),
        .op          (op),
        .Inm         (Inm),
        .pc_out      (pc_out),
        .pc_plus4    (pc_plus4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd0) return 32'h4000_0000;
        if (a == 32'd4) return 32'h5800_0000;
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]};
    endfunction

    always @(posedge clk) imem_rdata <= mem_word(imem_addr);

    // Stream model: after reset or a redirect the next valid instruction is two
    // unstalled edges away; stalls freeze everything; then one address per edge.
    logic        m_valid = 1'b0;
    logic [31:0] m_pc = '0;
    logic [31:0] m_next = RESET_PC;
    int          m_wait = 2;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_pc    <= '0;
            m_next  <= RESET_PC;
            m_wait  <= 2;
        end else if (PCsrc) begin
            m_valid <= 1'b0;
            m_next  <= pc_target;
            m_wait  <= 2;
        end else if (!stall) begin
            if (m_wait > 1) begin
                m_wait  <= m_wait - 1;
                m_valid <= 1'b0;
            end else begin
                m_wait  <= 0;
                m_valid <= 1'b1;
                m_pc    <= m_next;
                m_next  <= m_next + 32'd4;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    initial forever begin
        logic [31:0] w;
        logic [31:0] p4;
        @(negedge clk);
        if (!rst) begin
            check("model_valid", instr_valid, m_valid);
            if (m_valid) begin
                w  = mem_word(m_pc);
                p4 = m_pc + 32'd4;
                check("model_pc_out", pc_out, m_pc);
                check("model_instr", instr, w);
                check("model_fields", {tipo, op, Inm}, w[31:27]);
                check("model_pc_plus4", pc_plus4, p4);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_valid", instr_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_fields", {tipo, op, Inm}, 0);
        check("rst_pc_out", pc_out, 0);
        check("rst_pc_plus4", pc_plus4, 4);
        check("rst_addr", imem_addr, RESET_PC);
        #2 rst = 1'b0;
        @(negedge clk);
        check("edge1_valid", instr_valid, 0);
        @(negedge clk);
        check("first_valid", instr_valid, 1);
        check("first_fields", {tipo, op, Inm}, 5'b01_00_0);
        check("first_pc", pc_out, 0);
        @(negedge clk);
        check("second_fields", {tipo, op, Inm}, 5'b01_01_1);
        check("second_pc", pc_out, 4);
        for (int i = 2; i < 8; i++) begin
            @(negedge clk);
            check("stream_pc", pc_out, 4 * i);
            check("stream_pc_plus4", pc_plus4, 4 * i + 4);
        end

        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("restart_pc0", pc_out, 0);
        repeat (2) @(negedge clk);
        check("prestall_pc", pc_out, 8);
        #2 stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_hold_pc", pc_out, 8);
            check("stall_hold_valid", instr_valid, 1);
        end
        #2 stall = 1'b0;
        @(negedge clk);
        check("release_pc12", pc_out, 12);
        @(negedge clk);
        check("release_pc16", pc_out, 16);
        @(negedge clk);
        check("preredirect_pc", pc_out, 20);

        #2 begin PCsrc = 1'b1; pc_target = 32'h100; end
        @(negedge clk);
        check("redir_bubble1", instr_valid, 0);
        check("redir_addr", imem_addr, 32'h100);
        #2 PCsrc = 1'b0;
        @(negedge clk);
        check("redir_bubble2", instr_valid, 0);
        @(negedge clk);
        check("redir_valid", instr_valid, 1);
        check("redir_pc", pc_out, 32'h100);

        #2 stall = 1'b1;
        @(negedge clk);
        check("skid_full_pc", pc_out, 32'h100);
        #2 begin PCsrc = 1'b1; pc_target = 32'h200; end
        @(negedge clk);
        check("flush_bubble1", instr_valid, 0);
        check("flush_addr", imem_addr, 32'h200);
        #2 begin PCsrc = 1'b0; stall = 1'b0; end
        @(negedge clk);
        check("flush_bubble2", instr_valid, 0);
        @(negedge clk);
        check("flush_pc", pc_out, 32'h200);

        #2 begin PCsrc = 1'b1; pc_target = 32'hFFFF_FFF8; end
        @(negedge clk);
        #2 PCsrc = 1'b0;
        repeat (2) @(negedge clk);
        check("wrap_pc_hi", pc_out, 32'hFFFF_FFF8);
        @(negedge clk);
        check("wrap_pc_top", pc_out, 32'hFFFF_FFFC);
        check("wrap_pc_plus4", pc_plus4, 0);
        @(negedge clk);
        check("wrap_pc_zero", pc_out, 0);
        check("wrap_instr", instr, 32'h4000_0000);

        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", instr_valid, 0);
        check("async_rst_addr", imem_addr, RESET_PC);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("async_restart_pc", pc_out, RESET_PC);
        check("async_restart_valid", instr_valid, 1);
        #2 stall = 1'b1;
        @(negedge clk);
        #2 stall = 1'b0;
        repeat (4) @(negedge clk);
        check("single_stall_pc", pc_out, 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
